// File: rtl/fetch_pkg.sv
// Shared widths, constants and BTB entry layout for the instruction-fetch stage.
package fetch_pkg;
  localparam int PC_W      = 8;
  localparam int INSTR_W   = 32;
  localparam int BTB_IDX_W = 4;
  localparam int CNT_W     = 16;
  localparam int BTB_TAG_W = PC_W - BTB_IDX_W;

  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [PC_W-1:0]      target;
  } btb_entry_t;
endpackage

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer: synchronous write, combinational lookup,
// valid bits cleared by reset (tag/target storage is left untouched).
module branch_target_buffer #(
  parameter int PC_W  = 8,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic [PC_W-1:0] target,
  input  logic            update_en,
  input  logic [PC_W-1:0] update_pc,
  input  logic [PC_W-1:0] update_target
);
  localparam int TAG_W = PC_W - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } row_t;

  row_t             rows_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg;

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [TAG_W-1:0] update_tag;
  row_t             lookup_row;

  assign lookup_idx = lookup_pc[IDX_W-1:0];
  assign lookup_tag = lookup_pc[PC_W-1:IDX_W];
  assign update_idx = update_pc[IDX_W-1:0];
  assign update_tag = update_pc[PC_W-1:IDX_W];

  always_ff @(posedge clk) begin
    if (reset)
      valid_reg <= '0;
    else if (update_en)
      valid_reg[update_idx] <= 1'b1;
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (!reset && update_en)
      rows_reg[update_idx] <= '{tag: update_tag, target: update_target};
  end

  // Reads see pre-edge contents, so a same-cycle write is visible only next cycle.
  assign lookup_row = rows_reg[lookup_idx];
  assign hit        = valid_reg[lookup_idx] && (lookup_row.tag == lookup_tag);
  assign target     = lookup_row.target;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection with BTB-qualified
// prediction, IF/ID pipeline register and a saturating redirect counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W      = fetch_pkg::PC_W,
  parameter int INSTR_W   = fetch_pkg::INSTR_W,
  parameter int BTB_IDX_W = fetch_pkg::BTB_IDX_W,
  parameter int CNT_W     = fetch_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               mispredict,
  input  logic [PC_W-1:0]    CorrectedPC,
  input  logic               prediction,
  input  logic [INSTR_W-1:0] instr,
  input  logic               btbUpdate,
  input  logic [PC_W-1:0]    btbUpdatePC,
  input  logic [PC_W-1:0]    btbUpdateTarget,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pcD,
  output logic [INSTR_W-1:0] instrD,
  output logic               predictionD,
  output logic               validD,
  output logic [CNT_W-1:0]   mispredictCount
);
  logic            btb_hit;
  logic [PC_W-1:0] btb_target;
  logic            pred_taken;
  logic [PC_W-1:0] pc_next;

  branch_target_buffer #(
    .PC_W  (PC_W),
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (pc),
    .hit           (btb_hit),
    .target        (btb_target),
    .update_en     (btbUpdate),
    .update_pc     (btbUpdatePC),
    .update_target (btbUpdateTarget)
  );

  // A taken prediction without a BTB target is useless, so a miss falls through.
  assign pred_taken = prediction & btb_hit;

  always_comb begin
    pc_next = pc + PC_W'(1);
    if (mispredict)
      pc_next = CorrectedPC;
    else if (stall)
      pc_next = pc;
    else if (pred_taken)
      pc_next = btb_target;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= '0;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset || mispredict) begin
      pcD         <= '0;
      instrD      <= INSTR_W'(NOP);
      predictionD <= 1'b0;
      validD      <= 1'b0;
    end else if (!stall) begin
      pcD         <= pc;
      instrD      <= instr;
      predictionD <= pred_taken;
      validD      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      mispredictCount <= '0;
    else if (mispredict && (mispredictCount != '1))
      mispredictCount <= mispredictCount + CNT_W'(1);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences for
// wrap/stall/saturation, then randomized traffic against a behavioural model.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, mispredict, prediction, btbUpdate;
  logic [7:0]  CorrectedPC, btbUpdatePC, btbUpdateTarget;
  logic [31:0] instr, instr_s;
  logic [7:0]  pc, pcD, pc_s, pcD_s;
  logic [31:0] instrD, instrD_s;
  logic        predictionD, validD, predictionD_s, validD_s;
  logic [15:0] mispredictCount;
  logic [3:0]  mispredictCount_s;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hC0DE, a, ~a};
  endfunction

  assign instr   = mem_word(pc);
  assign instr_s = mem_word(pc_s);

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .mispredict(mispredict),
    .CorrectedPC(CorrectedPC), .prediction(prediction), .instr(instr),
    .btbUpdate(btbUpdate), .btbUpdatePC(btbUpdatePC), .btbUpdateTarget(btbUpdateTarget),
    .pc(pc), .pcD(pcD), .instrD(instrD), .predictionD(predictionD),
    .validD(validD), .mispredictCount(mispredictCount)
  );

  fetch_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .mispredict(mispredict),
    .CorrectedPC(CorrectedPC), .prediction(prediction), .instr(instr_s),
    .btbUpdate(btbUpdate), .btbUpdatePC(btbUpdatePC), .btbUpdateTarget(btbUpdateTarget),
    .pc(pc_s), .pcD(pcD_s), .instrD(instrD_s), .predictionD(predictionD_s),
    .validD(validD_s), .mispredictCount(mispredictCount_s)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural reference: BTB as plain arrays, PC as an integer.
  int          m_pc, m_pcD, m_cnt, m_cnt4;
  logic [31:0] m_instrD;
  bit          m_predD, m_validD;
  bit          bvalid [16];
  int          btag   [16];
  int          btgt   [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  idx;
    bit  hit, taken;
    idx   = m_pc % 16;
    hit   = bvalid[idx] && (btag[idx] == m_pc / 16);
    taken = prediction && hit;
    if (reset) begin
      m_pc = 0; m_pcD = 0; m_instrD = 0; m_predD = 0; m_validD = 0;
      m_cnt = 0; m_cnt4 = 0;
      for (int i = 0; i < 16; i++) bvalid[i] = 0;
    end else begin
      if (mispredict) begin
        m_pc = CorrectedPC;
        m_pcD = 0; m_instrD = 0; m_predD = 0; m_validD = 0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end else if (!stall) begin
        m_pcD    = m_pc;
        m_instrD = mem_word(8'(m_pc));
        m_predD  = taken;
        m_validD = 1;
        m_pc     = taken ? btgt[idx] : (m_pc + 1) % 256;
      end
      if (btbUpdate) begin
        bvalid[btbUpdatePC % 16] = 1;
        btag[btbUpdatePC % 16]   = btbUpdatePC / 16;
        btgt[btbUpdatePC % 16]   = btbUpdateTarget;
      end
    end
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check("pc",          32'(pc),              32'(m_pc));
    check("pcD",         32'(pcD),             32'(m_pcD));
    check("instrD",      instrD,               m_instrD);
    check("predictionD", 32'(predictionD),     32'(m_predD));
    check("validD",      32'(validD),          32'(m_validD));
    check("count16",     32'(mispredictCount), 32'(m_cnt));
    check("count4",      32'(mispredictCount_s), 32'(m_cnt4));
    check("pc_small",    32'(pc_s),            32'(m_pc));
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; mispredict = 0; CorrectedPC = 0; prediction = 0;
    btbUpdate = 0; btbUpdatePC = 0; btbUpdateTarget = 0;
  endtask

  typedef struct {
    bit         rst, stl, mis;
    logic [7:0] cpc;
    bit         pred, upd;
    logic [7:0] upc, utgt;
    logic [7:0] e_pc, e_pcD;
    bit         e_v, e_p;
    int         e_cnt;
  } vec_t;

  vec_t tbl [24];

  initial begin
    idle_inputs();
    tbl[0]  = '{1,0,0,8'h00,0,0,8'h00,8'h00, 8'h00,8'h00,0,0,0};
    tbl[1]  = '{1,0,0,8'h00,0,0,8'h00,8'h00, 8'h00,8'h00,0,0,0};
    tbl[2]  = '{0,0,0,8'h00,0,0,8'h00,8'h00, 8'h01,8'h00,1,0,0};
    tbl[3]  = '{0,0,0,8'h00,0,0,8'h00,8'h00, 8'h02,8'h01,1,0,0};
    tbl[4]  = '{0,0,0,8'h00,0,1,8'h05,8'h40, 8'h03,8'h02,1,0,0};
    tbl[5]  = '{0,0,0,8'h00,0,0,8'h00,8'h00, 8'h04,8'h03,1,0,0};
    tbl[6]  = '{0,0,0,8'h00,1,0,8'h00,8'h00, 8'h05,8'h04,1,0,0};
    tbl[7]  = '{0,0,0,8'h00,1,0,8'h00,8'h00, 8'h40,8'h05,1,1,0};
    tbl[8]  = '{0,0,0,8'h00,0,0,8'h00,8'h00, 8'h41,8'h40,1,0,0};
    tbl[9]  = '{0,1,1,8'h20,0,0,8'h00,8'h00, 8'h20,8'h00,0,0,1};
    tbl[10] = '{0,0,0,8'h00,0,0,8'h00,8'h00, 8'h21,8'h20,1,0,1};
    tbl[11] = '{0,1,0,8'h00,0,0,8'h00,8'h00, 8'h21,8'h20,1,0,1};
    tbl[12] = '{0,0,1,8'h13,0,1,8'h03,8'h77, 8'h13,8'h00,0,0,2};
    tbl[13] = '{0,0,0,8'h00,1,0,8'h00,8'h00, 8'h14,8'h13,1,0,2};
    tbl[14] = '{0,0,0,8'h00,1,1,8'h14,8'h60, 8'h15,8'h14,1,0,2};
    tbl[15] = '{0,0,1,8'h14,0,0,8'h00,8'h00, 8'h14,8'h00,0,0,3};
    tbl[16] = '{0,0,0,8'h00,1,0,8'h00,8'h00, 8'h60,8'h14,1,1,3};
    tbl[17] = '{0,0,1,8'h05,0,0,8'h00,8'h00, 8'h05,8'h00,0,0,4};
    tbl[18] = '{0,0,0,8'h00,0,0,8'h00,8'h00, 8'h06,8'h05,1,0,4};
    tbl[19] = '{1,1,1,8'h55,1,1,8'h60,8'h70, 8'h00,8'h00,0,0,0};
    tbl[20] = '{0,0,1,8'h05,0,0,8'h00,8'h00, 8'h05,8'h00,0,0,1};
    tbl[21] = '{0,0,0,8'h00,1,0,8'h00,8'h00, 8'h06,8'h05,1,0,1};
    tbl[22] = '{0,0,1,8'h60,0,0,8'h00,8'h00, 8'h60,8'h00,0,0,2};
    tbl[23] = '{0,0,0,8'h00,1,0,8'h00,8'h00, 8'h61,8'h60,1,0,2};

    for (int i = 0; i < 24; i++) begin
      reset = tbl[i].rst; stall = tbl[i].stl; mispredict = tbl[i].mis;
      CorrectedPC = tbl[i].cpc; prediction = tbl[i].pred;
      btbUpdate = tbl[i].upd; btbUpdatePC = tbl[i].upc; btbUpdateTarget = tbl[i].utgt;
      step();
      check("vec_pc",     32'(pc),              32'(tbl[i].e_pc));
      check("vec_pcD",    32'(pcD),             32'(tbl[i].e_pcD));
      check("vec_validD", 32'(validD),          32'(tbl[i].e_v));
      check("vec_predD",  32'(predictionD),     32'(tbl[i].e_p));
      check("vec_instrD", instrD,               tbl[i].e_v ? mem_word(tbl[i].e_pcD) : 32'h0);
      check("vec_count",  32'(mispredictCount), 32'(tbl[i].e_cnt));
      $display("[TB] vec %0d pc=%h pcD=%h instrD=%h validD=%b predD=%b cnt=%0d",
               i, pc, pcD, instrD, validD, predictionD, mispredictCount);
    end

    // PC wraps from FF to 00.
    idle_inputs(); mispredict = 1; CorrectedPC = 8'hFE; step();
    idle_inputs(); step();
    check("wrap_pc_ff", 32'(pc), 32'h0000_00FF);
    step();
    check("wrap_pc_00", 32'(pc), 32'h0000_0000);
    check("wrap_pcD",   32'(pcD), 32'h0000_00FF);
    $display("[TB] wrap pc=%h pcD=%h", pc, pcD);

    // Three-cycle stall at 0x10 freezes PC and IF/ID, then fetch resumes at 0x11.
    mispredict = 1; CorrectedPC = 8'h0F; step();
    idle_inputs(); step();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc",     32'(pc),     32'h0000_0010);
      check("stall_pcD",    32'(pcD),    32'h0000_000F);
      check("stall_instrD", instrD,      mem_word(8'h0F));
      check("stall_validD", 32'(validD), 32'd1);
    end
    stall = 0; step();
    check("resume_pc",  32'(pc),  32'h0000_0011);
    check("resume_pcD", 32'(pcD), 32'h0000_0010);
    $display("[TB] stall release pc=%h pcD=%h", pc, pcD);

    // Counter saturation on the 4-bit instance.
    reset = 1; step();
    reset = 0; mispredict = 1;
    for (int k = 0; k < 20; k++) begin
      CorrectedPC = 8'($urandom_range(0, 255));
      step();
    end
    check("sat_count4",  32'(mispredictCount_s), 32'h0000_000F);
    check("sat_count16", 32'(mispredictCount),   32'd20);
    $display("[TB] saturation count4=%h count16=%0d", mispredictCount_s, mispredictCount);

    // Randomized traffic; addresses kept in a small window so BTB hits are common.
    idle_inputs();
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 199) == 0);
      mispredict      = ($urandom_range(0, 9) == 0);
      stall           = ($urandom_range(0, 5) == 0);
      CorrectedPC     = 8'($urandom_range(0, 63));
      prediction      = $urandom_range(0, 1) == 1;
      btbUpdate       = ($urandom_range(0, 3) == 0);
      btbUpdatePC     = 8'($urandom_range(0, 63));
      btbUpdateTarget = 8'($urandom_range(0, 63));
      step();
    end
    $display("[TB] random phase done pc=%h cnt=%0d", pc, mispredictCount);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
